banked_sram_array: RTL and testbench
====================================

Name: banked_sram_array

Overview:
- Parametrised storage wrapper that builds one flat word-addressed memory out of NUM_BANKS banks of single-port SRAM macros.
- Each bank is SLICES slices of SLICE_WIDTH bits wide.
- Provides an independent write (load) port and read (compute) port with valid/ready handshakes, per-bank conflict arbitration, registered bank-select read muxing and out-of-range detection.
- Replaces the fixed two-bank weight and feature-map storage. It sits between the DMA/load path and the convolution datapath.

Parameters:
- SLICE_WIDTH, 104, bits per macro instance.
- SLICES, 2, macros side by side per bank; DATA_WIDTH = SLICE_WIDTH*SLICES.
- BANK_DEPTH, 520, words per bank; need not be a power of two.
- NUM_BANKS, 2, number of banks stacked in the address space.
- ADDR_WIDTH, 11, flat address width; must satisfy 2^ADDR_WIDTH >= NUM_BANKS*BANK_DEPTH.
- LOCAL_AW, 10, macro address width; must satisfy 2^LOCAL_AW >= BANK_DEPTH.
- OUT_REG, 0, 1 adds an output register stage on rd_data.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle when wr_valid&wr_ready.
- wr_addr  in  ADDR_WIDTH  flat write address.
- wr_data  in  DATA_WIDTH  write data; slice k = bits [k*SLICE_WIDTH +: SLICE_WIDTH].
- rd_valid  in  1  read request; always accepted.
- rd_addr  in  ADDR_WIDTH  flat read address.
- rd_data  out  DATA_WIDTH  read data, qualified by rd_data_valid.
- rd_data_valid  out  1  one-cycle pulse per accepted read.
- rd_err  out  1  pulse aligned with rd_data_valid for an out-of-range read.
- wr_err  out  1  pulse in the cycle after an out-of-range write is accepted.

Behaviour:
- Decode: bank = addr / BANK_DEPTH, local = addr - bank*BANK_DEPTH. Implement with a compare chain against k*BANK_DEPTH, no divider.
- Out of range: addr >= NUM_BANKS*BANK_DEPTH. No macro is accessed.
- Macro interface per slice: active-low CEN and WEN, A[LOCAL_AW], D, Q, 1-cycle read. Tie EMA=3'd7, EMAW=2'd3, RET1N=1.
- All slices of a bank share CEN, WEN and A.
- Bank b CEN is low only when rst is high and one of:
  - an accepted in-range read targets b (WEN high, A = read local address), or
  - an accepted in-range write targets b (WEN low, A = write local address, D = wr_data).
- Idle banks hold CEN high (power saving).
- Reads have fixed priority; rd_ready is implicit 1.
- wr_ready = 0 when rd_valid is high, rd_addr is in range, and rd_addr decodes to the same bank as wr_addr; wr_ready = 1 otherwise. wr_ready is combinational.
  - Stalled writes must hold wr_addr/wr_data until accepted.
  - Out-of-range writes are never stalled.
- Different-bank read and write proceed in the same cycle.
- Read/write to the same address cannot co-occur (the write stalls). A read issued the cycle after a write to the same address returns the new data.
- Read pipeline:
  - An accepted read registers its bank index and out-of-range flag.
  - Read latency is 1+OUT_REG cycles from acceptance (acceptance cycle = cycle 0).
  - OUT_REG=0: rd_data = Q of the registered bank. Selection uses the registered bank index, never the live rd_addr.
  - OUT_REG=1: that mux result is registered, and rd_data_valid/rd_err are delayed one more cycle.
- Out-of-range read: rd_data = 0 with rd_data_valid=1 and rd_err=1 at normal latency.
- Back-to-back reads every cycle are supported at full throughput, with no bubbles.
- Reset values: rd_data_valid=0, rd_err=0, wr_err=0, registered bank select=0, rd_data=0 (OUT_REG=1).
  - rd_data is unspecified when OUT_REG=0.
  - wr_ready is combinational, so it is not reset.
- Reset mid-operation: any read in flight when rst falls produces no rd_data_valid. The first rising edge with rst high starts clean.
- Writes in the cycle rst is low are dropped; wr_ready may still be high.
- Memory contents are not cleared by reset.

Test Plan:
- OUT_REG=0: write addr 5 = 208'hA5..A5, then read addr 5 -> rd_data_valid 1 cycle after accept, rd_data=A5..A5, rd_err=0.
- Boundary: write 519=X, 520=Y, 0=Z; read 519,520,0 back-to-back -> X,Y,Z on consecutive cycles. Bank1 local 0 holds Y; bank0 local 0 holds Z.
- Same-bank conflict: same cycle rd_addr=10, wr_addr=20 (both bank0) -> wr_ready=0, only bank0 CEN low (read). Write lands next cycle; read of 20 afterward returns new data.
- Cross-bank: rd_addr=10 with wr_addr=600 -> wr_ready=1, both bank CENs low same cycle. Read 600 later returns written data.
- Errors: rd_addr=1040 -> rd_data_valid=1, rd_err=1, rd_data=0 one cycle later, all CENs high. wr_addr=1100 -> wr_err pulse next cycle, no CEN low.
- Reset/OUT_REG: OUT_REG=1, read accepted, rst low for 1 cycle the next edge -> no rd_data_valid pulse. Normal read latency after reset release is 2 cycles.

Source files
------------

// File: rtl/banked_sram_array.sv
// Flat word-addressed memory built from NUM_BANKS banks of single-port SRAM slices.
// Independent load (write) and compute (read) ports; reads win bank conflicts.

module sram_sp_macro #(
    parameter int WIDTH = 104,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             CEN,
    input  logic             WEN,
    input  logic [AW-1:0]    A,
    input  logic [WIDTH-1:0] D,
    input  logic [2:0]       EMA,
    input  logic [1:0]       EMAW,
    input  logic             RET1N,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] mem [1<<AW];
    logic             unusedTie;

    // Timing-margin and retention pins only matter on silicon.
    assign unusedTie = ^{EMA, EMAW, RET1N};

    always_ff @(posedge clk) begin
        if (!CEN) begin
            if (!WEN) mem[A] <= D;
            else      Q      <= mem[A];
        end
    end
endmodule

module banked_sram_array #(
    parameter int SLICE_WIDTH = 104,
    parameter int SLICES      = 2,
    parameter int BANK_DEPTH  = 520,
    parameter int NUM_BANKS   = 2,
    parameter int ADDR_WIDTH  = 11,
    parameter int LOCAL_AW    = 10,
    parameter int OUT_REG     = 0,
    localparam int DATA_WIDTH = SLICE_WIDTH * SLICES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_err,
    output logic                  wr_err
);
    localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int TOTAL_WORDS = NUM_BANKS * BANK_DEPTH;

    function automatic logic [BANK_W-1:0] bankOf(input logic [ADDR_WIDTH-1:0] addr);
        logic [BANK_W-1:0] bank = '0;
        for (int k = 1; k < NUM_BANKS; k++)
            if (int'(addr) >= k * BANK_DEPTH) bank = BANK_W'(k);
        return bank;
    endfunction

    function automatic logic [LOCAL_AW-1:0] localOf(input logic [ADDR_WIDTH-1:0] addr);
        int base = 0;
        for (int k = 1; k < NUM_BANKS; k++)
            if (int'(addr) >= k * BANK_DEPTH) base = k * BANK_DEPTH;
        return LOCAL_AW'(int'(addr) - base);
    endfunction

    function automatic logic inRange(input logic [ADDR_WIDTH-1:0] addr);
        return int'(addr) < TOTAL_WORDS;
    endfunction

    logic [BANK_W-1:0]     rdBank, wrBank;
    logic [LOCAL_AW-1:0]   rdLocal, wrLocal;
    logic                  rdInRange, wrInRange;
    logic                  rdAcc, wrTake, wrAcc;
    logic [NUM_BANKS-1:0]  bankCen, bankWen;
    logic [LOCAL_AW-1:0]   bankA [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bankQ [NUM_BANKS];

    assign rdBank    = bankOf(rd_addr);
    assign wrBank    = bankOf(wr_addr);
    assign rdLocal   = localOf(rd_addr);
    assign wrLocal   = localOf(wr_addr);
    assign rdInRange = inRange(rd_addr);
    assign wrInRange = inRange(wr_addr);

    // Only an in-range read can block a write, and only on the bank it occupies.
    assign wr_ready = !(rd_valid && rdInRange && wrInRange && (rdBank == wrBank));
    assign wrTake   = wr_valid && wr_ready;
    assign rdAcc    = rst && rd_valid && rdInRange;
    assign wrAcc    = rst && wrTake && wrInRange;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : genBank
        logic rdHit, wrHit;
        assign rdHit      = rdAcc && (rdBank == BANK_W'(b));
        assign wrHit      = wrAcc && (wrBank == BANK_W'(b)) && !rdHit;
        assign bankCen[b] = !(rdHit || wrHit);
        assign bankWen[b] = !wrHit;
        assign bankA[b]   = wrHit ? wrLocal : rdLocal;

        for (genvar s = 0; s < SLICES; s++) begin : genSlice
            sram_sp_macro #(
                .WIDTH (SLICE_WIDTH),
                .AW    (LOCAL_AW)
            ) uMacro (
                .clk   (clk),
                .CEN   (bankCen[b]),
                .WEN   (bankWen[b]),
                .A     (bankA[b]),
                .D     (wr_data[s*SLICE_WIDTH +: SLICE_WIDTH]),
                .EMA   (3'd7),
                .EMAW  (2'd3),
                .RET1N (1'b1),
                .Q     (bankQ[b][s*SLICE_WIDTH +: SLICE_WIDTH])
            );
        end
    end

    // Stage p1: acceptance edge captures read bank select and error flags
    logic                  vld_p1, rdErr_p1, wrErr_p1;
    logic [BANK_W-1:0]     rdBank_p1;
    logic [DATA_WIDTH-1:0] muxData_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1    <= 1'b0;
            rdErr_p1  <= 1'b0;
            wrErr_p1  <= 1'b0;
            rdBank_p1 <= '0;
        end else begin
            vld_p1   <= rd_valid;
            rdErr_p1 <= rd_valid && !rdInRange;
            wrErr_p1 <= wrTake && !wrInRange;
            if (rd_valid) rdBank_p1 <= rdBank;
        end
    end

    assign muxData_p1 = rdErr_p1 ? '0 : bankQ[rdBank_p1];
    assign wr_err     = wrErr_p1;

    // Stage p2: optional output register
    if (OUT_REG != 0) begin : genOutReg
        logic                  vld_p2, rdErr_p2;
        logic [DATA_WIDTH-1:0] rdData_p2;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_p2    <= 1'b0;
                rdErr_p2  <= 1'b0;
                rdData_p2 <= '0;
            end else begin
                vld_p2   <= vld_p1;
                rdErr_p2 <= rdErr_p1;
                if (vld_p1) rdData_p2 <= muxData_p1;
            end
        end

        assign rd_data       = rdData_p2;
        assign rd_data_valid = vld_p2;
        assign rd_err        = rdErr_p2;
    end else begin : genNoOutReg
        assign rd_data       = muxData_p1;
        assign rd_data_valid = vld_p1;
        assign rd_err        = rdErr_p1;
    end
endmodule

// File: tb/tb_banked_sram_array.sv
// Bench for banked_sram_array: one instance without and one with the output register,
// both driven by the same stimulus and checked against a flat-array reference memory.

module tb_banked_sram_array;
    localparam int DW    = 208;
    localparam int DEPTH = 520;
    localparam int TOTAL = 1040;

    logic          clk, rst;
    logic          wr_valid, rd_valid;
    logic [10:0]   wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wrReady0, rdVld0, rdErr0, wrErr0;
    logic          wrReady1, rdVld1, rdErr1, wrErr1;
    logic [DW-1:0] rdData0, rdData1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] refMem [TOTAL];

    banked_sram_array #(.OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wrReady0), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rdData0),
        .rd_data_valid(rdVld0), .rd_err(rdErr0), .wr_err(wrErr0)
    );

    banked_sram_array #(.OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wrReady1), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rdData1),
        .rd_data_valid(rdVld1), .rd_err(rdErr1), .wr_err(wrErr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] randWord();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < 7; i++) w = {w[DW-33:0], 32'($urandom())};
        return w;
    endfunction

    function automatic logic [DW-1:0] refRead(input int a);
        return (a < TOTAL) ? refMem[a] : '0;
    endfunction

    function automatic logic [10:0] randAddr();
        int r = $urandom_range(0, 9);
        if (r < 4)      return 11'($urandom_range(0, 15));
        else if (r < 8) return 11'(DEPTH + $urandom_range(0, 15));
        else            return 11'(TOTAL + $urandom_range(0, 60));
    endfunction

    task automatic doWrite(input int a, input logic [DW-1:0] d);
        rd_valid = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 11'(a);
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        if (a < TOTAL) refMem[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        checks++; if (rdVld0 !== 1'b0) begin errors++; $display("FAIL reset_vld0 got %b want 0", rdVld0); end
        checks++; if (rdErr0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b want 0", rdErr0); end
        checks++; if (wrErr0 !== 1'b0) begin errors++; $display("FAIL reset_wrerr0 got %b want 0", wrErr0); end
        checks++; if (rdVld1 !== 1'b0) begin errors++; $display("FAIL reset_vld1 got %b want 0", rdVld1); end
        checks++; if (rdData1 !== '0) begin errors++; $display("FAIL reset_data1 got %h want 0", rdData1); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] pat = {26{8'hA5}};
        doWrite(5, pat);
        rd_valid = 1'b1; rd_addr = 11'd5;
        tick();
        rd_valid = 1'b0;
        checks++; if (rdVld0 !== 1'b1) begin errors++; $display("FAIL basic_vld0 got %b want 1", rdVld0); end
        checks++; if (rdData0 !== pat) begin errors++; $display("FAIL basic_data0 got %h want %h", rdData0, pat); end
        checks++; if (rdErr0 !== 1'b0) begin errors++; $display("FAIL basic_err0 got %b want 0", rdErr0); end
        checks++; if (rdVld1 !== 1'b0) begin errors++; $display("FAIL basic_vld1_early got %b want 0", rdVld1); end
        tick();
        checks++; if (rdVld0 !== 1'b0) begin errors++; $display("FAIL basic_vld0_pulse got %b want 0", rdVld0); end
        checks++; if (rdVld1 !== 1'b1) begin errors++; $display("FAIL basic_vld1 got %b want 1", rdVld1); end
        checks++; if (rdData1 !== pat) begin errors++; $display("FAIL basic_data1 got %h want %h", rdData1, pat); end
    endtask

    task automatic test_boundary();
        int            addrs [3] = '{519, 520, 0};
        logic [DW-1:0] bankWord;
        doWrite(519, randWord());
        doWrite(520, randWord());
        doWrite(0, randWord());
        for (int i = 0; i < 4; i++) begin
            rd_valid = (i < 3);
            if (i < 3) rd_addr = 11'(addrs[i]);
            tick();
            if (i < 3) begin
                checks++; if (rdVld0 !== 1'b1 || rdData0 !== refRead(addrs[i])) begin
                    errors++; $display("FAIL bound_rd0_%0d got %b/%h want 1/%h", addrs[i], rdVld0, rdData0, refRead(addrs[i]));
                end
            end
            if (i >= 1) begin
                checks++; if (rdVld1 !== 1'b1 || rdData1 !== refRead(addrs[i-1])) begin
                    errors++; $display("FAIL bound_rd1_%0d got %b/%h want 1/%h", addrs[i-1], rdVld1, rdData1, refRead(addrs[i-1]));
                end
            end
        end
        rd_valid = 1'b0;
        bankWord = {dut0.genBank[1].genSlice[1].uMacro.mem[0], dut0.genBank[1].genSlice[0].uMacro.mem[0]};
        checks++; if (bankWord !== refMem[520]) begin errors++; $display("FAIL bank1_local0 got %h want %h", bankWord, refMem[520]); end
        bankWord = {dut0.genBank[0].genSlice[1].uMacro.mem[0], dut0.genBank[0].genSlice[0].uMacro.mem[0]};
        checks++; if (bankWord !== refMem[0]) begin errors++; $display("FAIL bank0_local0 got %h want %h", bankWord, refMem[0]); end
    endtask

    task automatic test_conflict();
        logic [DW-1:0] d = randWord();
        doWrite(10, randWord());
        rd_valid = 1'b1; rd_addr = 11'd10;
        wr_valid = 1'b1; wr_addr = 11'd20; wr_data = d;
        #1;
        checks++; if (wrReady0 !== 1'b0) begin errors++; $display("FAIL conflict_ready got %b want 0", wrReady0); end
        checks++; if (dut0.bankCen !== 2'b10) begin errors++; $display("FAIL conflict_cen got %b want 10", dut0.bankCen); end
        tick();
        rd_valid = 1'b0;
        checks++; if (rdData0 !== refRead(10)) begin errors++; $display("FAIL conflict_rd10 got %h want %h", rdData0, refRead(10)); end
        #1;
        checks++; if (wrReady0 !== 1'b1) begin errors++; $display("FAIL conflict_release got %b want 1", wrReady0); end
        tick();
        wr_valid = 1'b0;
        refMem[20] = d;
        rd_valid = 1'b1; rd_addr = 11'd20;
        tick();
        rd_valid = 1'b0;
        checks++; if (rdData0 !== d) begin errors++; $display("FAIL conflict_rd20 got %h want %h", rdData0, d); end
    endtask

    task automatic test_cross();
        logic [DW-1:0] d = randWord();
        rd_valid = 1'b1; rd_addr = 11'd10;
        wr_valid = 1'b1; wr_addr = 11'd600; wr_data = d;
        #1;
        checks++; if (wrReady0 !== 1'b1) begin errors++; $display("FAIL cross_ready got %b want 1", wrReady0); end
        checks++; if (dut0.bankCen !== 2'b00) begin errors++; $display("FAIL cross_cen got %b want 00", dut0.bankCen); end
        tick();
        refMem[600] = d;
        wr_valid = 1'b0;
        checks++; if (rdData0 !== refRead(10)) begin errors++; $display("FAIL cross_rd10 got %h want %h", rdData0, refRead(10)); end
        rd_addr = 11'd600;
        tick();
        rd_valid = 1'b0;
        checks++; if (rdData0 !== d) begin errors++; $display("FAIL cross_rd600 got %h want %h", rdData0, d); end
    endtask

    task automatic test_errors();
        rd_valid = 1'b1; rd_addr = 11'd1040;
        #1;
        checks++; if (dut0.bankCen !== 2'b11) begin errors++; $display("FAIL oor_rd_cen got %b want 11", dut0.bankCen); end
        tick();
        rd_valid = 1'b0;
        checks++; if (rdVld0 !== 1'b1 || rdErr0 !== 1'b1) begin errors++; $display("FAIL oor_rd_flags0 got %b%b want 11", rdVld0, rdErr0); end
        checks++; if (rdData0 !== '0) begin errors++; $display("FAIL oor_rd_data0 got %h want 0", rdData0); end
        tick();
        checks++; if (rdVld1 !== 1'b1 || rdErr1 !== 1'b1 || rdData1 !== '0) begin
            errors++; $display("FAIL oor_rd_dut1 got %b%b/%h want 11/0", rdVld1, rdErr1, rdData1);
        end
        rd_valid = 1'b1; rd_addr = 11'd10;
        wr_valid = 1'b1; wr_addr = 11'd1100; wr_data = randWord();
        #1;
        checks++; if (wrReady0 !== 1'b1) begin errors++; $display("FAIL oor_wr_ready got %b want 1", wrReady0); end
        checks++; if (dut0.bankCen !== 2'b10) begin errors++; $display("FAIL oor_wr_cen got %b want 10", dut0.bankCen); end
        tick();
        rd_valid = 1'b0; wr_valid = 1'b0;
        checks++; if (wrErr0 !== 1'b1 || wrErr1 !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b%b want 11", wrErr0, wrErr1); end
        tick();
        checks++; if (wrErr0 !== 1'b0) begin errors++; $display("FAIL oor_wr_err_pulse got %b want 0", wrErr0); end
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] keep = randWord();
        doWrite(30, keep);
        rd_valid = 1'b1; rd_addr = 11'd30;
        tick();
        rd_valid = 1'b0;
        rst = 1'b0;
        wr_valid = 1'b1; wr_addr = 11'd30; wr_data = ~keep;
        tick();
        checks++; if (rdVld1 !== 1'b0 || rdVld0 !== 1'b0) begin errors++; $display("FAIL midrst_vld got %b%b want 00", rdVld0, rdVld1); end
        rst = 1'b1; wr_valid = 1'b0;
        tick();
        checks++; if (rdVld1 !== 1'b0) begin errors++; $display("FAIL midrst_vld1_after got %b want 0", rdVld1); end
        rd_valid = 1'b1; rd_addr = 11'd30;
        tick();
        rd_valid = 1'b0;
        checks++; if (rdVld1 !== 1'b0) begin errors++; $display("FAIL midrst_lat1 got %b want 0", rdVld1); end
        tick();
        checks++; if (rdVld1 !== 1'b1 || rdData1 !== keep) begin
            errors++; $display("FAIL midrst_lat2 got %b/%h want 1/%h", rdVld1, rdData1, keep);
        end
    endtask

    task automatic test_back_to_back();
        logic          pendW = 1'b0;
        logic [10:0]   pendA = '0;
        logic [DW-1:0] pendD = '0;
        logic          expReady, expWErr, curV, curE, prevV, prevE;
        logic [DW-1:0] curD, prevD;
        for (int a = 0; a < 16; a++) begin
            doWrite(a, randWord());
            doWrite(DEPTH + a, randWord());
        end
        rd_valid = 1'b0; wr_valid = 1'b0;
        tick(); tick();
        prevV = 1'b0; prevE = 1'b0; prevD = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pendW && ($urandom_range(0, 1) == 1)) begin
                pendW = 1'b1; pendA = randAddr(); pendD = randWord();
            end
            wr_valid = pendW; wr_addr = pendA; wr_data = pendD;
            curV = ($urandom_range(0, 3) != 0);
            rd_valid = curV; rd_addr = randAddr();
            #1;
            expReady = !(curV && rd_addr < TOTAL && pendA < TOTAL && (rd_addr / DEPTH) == (pendA / DEPTH));
            checks++; if (wrReady0 !== expReady || wrReady1 !== expReady) begin
                errors++; $display("FAIL rand_ready c%0d got %b%b want %b", c, wrReady0, wrReady1, expReady);
            end
            curE = (rd_addr >= TOTAL);
            curD = refRead(int'(rd_addr));
            tick();
            expWErr = pendW && expReady && (pendA >= TOTAL);
            if (pendW && expReady) begin
                if (pendA < TOTAL) refMem[pendA] = pendD;
                pendW = 1'b0;
            end
            checks++; if (rdVld0 !== curV || (curV && (rdErr0 !== curE || rdData0 !== curD))) begin
                errors++; $display("FAIL rand_rd0 c%0d got %b%b/%h want %b%b/%h", c, rdVld0, rdErr0, rdData0, curV, curE, curD);
            end
            checks++; if (rdVld1 !== prevV || (prevV && (rdErr1 !== prevE || rdData1 !== prevD))) begin
                errors++; $display("FAIL rand_rd1 c%0d got %b%b/%h want %b%b/%h", c, rdVld1, rdErr1, rdData1, prevV, prevE, prevD);
            end
            checks++; if (wrErr0 !== expWErr) begin errors++; $display("FAIL rand_wrerr c%0d got %b want %b", c, wrErr0, expWErr); end
            prevV = curV; prevE = curE; prevD = curD;
        end
        rd_valid = 1'b0; wr_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_conflict();
        test_cross();
        test_errors();
        test_reset_midflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
